hazard_ctrl: RTL

Parametrised load-use and control-hazard controller for the 5-stage RV32I pipeline. It sits between ID and EX. It tracks in-flight loads in a small age scoreboard so the stall length follows a configurable data-memory latency. It also converts an EX-stage redirect into IF/ID and ID/EX flushes. It drives the PC-write, IF/ID-write, bubble and flush controls for the whole pipeline.

---
 rtl/hazard_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use and control-hazard controller sitting between ID and EX.
// Loads are tracked in a small age scoreboard, so the stall length follows the
// data-memory latency LOAD_LAT (1..4). An EX-stage redirect flushes IF/ID and
// bubbles ID/EX.
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating stall and
// flush performance counters; otherwise stall_cnt and flush_cnt are tied to 0.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [6:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_redirect,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

  logic use_rs1_s;
  logic use_rs2_s;
  logic ex_load_s;
  logic sb_hit_rs1_s;
  logic sb_hit_rs2_s;
  logic hazard_s;
  logic stall_s;
  logic flush_s;

  // With a single-bubble latency and no counters, clk has no other reader.
  logic unused_clk_s;
  assign unused_clk_s = clk;

  // Decode which source fields the ID instruction actually reads.
  always_comb begin
    use_rs1_s = 1'b1;
    use_rs2_s = 1'b0;
    case (id_opcode)
      OP_LUI, OP_AUIPC, OP_JAL: begin
        use_rs1_s = 1'b0;
        use_rs2_s = 1'b0;
      end
      OP_RTYPE, OP_STORE, OP_BRANCH: begin
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
      end
      default: begin
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b0;
      end
    endcase
  end

  // A load writing x0 never produces a usable result, so it is not tracked.
  assign ex_load_s = ex_valid & ex_mem_read & (ex_rd != REG_ZERO);

  generate
    if (LOAD_LAT > 1) begin : g_sb
      localparam int SB_N = LOAD_LAT - 1;
      logic [SB_N-1:0]       sb_v_q;
      logic [SB_N-1:0]       sb_v_d;
      logic [REG_ADDR_W-1:0] sb_rd_q [SB_N];
      logic [REG_ADDR_W-1:0] sb_rd_d [SB_N];

      // Age every tracked load by one slot; EX always advances, so no hold.
      always_comb begin
        sb_v_d     = sb_v_q;
        sb_v_d[0]  = ex_load_s;
        sb_rd_d    = sb_rd_q;
        sb_rd_d[0] = ex_rd;
        for (int i = 1; i < SB_N; i++) begin
          sb_v_d[i]  = sb_v_q[i-1];
          sb_rd_d[i] = sb_rd_q[i-1];
        end
      end

      // Scoreboard register; only the valid bits need clearing on reset.
      always_ff @(posedge clk) begin
        if (!reset) begin
          sb_v_q <= {SB_N{1'b0}};
        end else begin
          sb_v_q <= sb_v_d;
        end
        for (int i = 0; i < SB_N; i++) begin
          sb_rd_q[i] <= sb_rd_d[i];
        end
      end

      // Match the ID sources against every live scoreboard entry.
      always_comb begin
        sb_hit_rs1_s = 1'b0;
        sb_hit_rs2_s = 1'b0;
        for (int i = 0; i < SB_N; i++) begin
          sb_hit_rs1_s = sb_hit_rs1_s | (sb_v_q[i] & (sb_rd_q[i] == id_rs1));
          sb_hit_rs2_s = sb_hit_rs2_s | (sb_v_q[i] & (sb_rd_q[i] == id_rs2));
        end
      end
    end else begin : g_no_sb
      assign sb_hit_rs1_s = 1'b0;
      assign sb_hit_rs2_s = 1'b0;
    end
  endgenerate

  // Load-use hazard: a used, non-zero source hits the load in EX or in flight.
  always_comb begin
    hazard_s = id_valid & (
                 (use_rs1_s & (id_rs1 != REG_ZERO) &
                  ((ex_load_s & (ex_rd == id_rs1)) | sb_hit_rs1_s)) |
                 (use_rs2_s & (id_rs2 != REG_ZERO) &
                  ((ex_load_s & (ex_rd == id_rs2)) | sb_hit_rs2_s)));
    flush_s  = ex_redirect;
    stall_s  = hazard_s & ~ex_redirect;
  end

  // Pipeline controls: reset holds the pipe empty, then flush > stall > run.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (!reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
    end else if (flush_s) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
    end else if (stall_s) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b0;
    end else begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  // Saturating increments; a counter parked at all-ones stays there.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_s && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
